// File: rtl/lsu_pkg.sv
// Shared core definitions: widths, opcodes, ALU ops, memory size encodings,
// LSU FSM state and request payload, plus byte-lane helpers.
package lsu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned REG_W  = 5;

  // Major opcodes
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  // ALU operations
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
  } alu_op_e;

  // Memory access size encodings (shared by load and store)
  localparam logic [1:0] MEM_SZ_NONE = 2'b00;
  localparam logic [1:0] MEM_SZ_BYTE = 2'b01;
  localparam logic [1:0] MEM_SZ_HALF = 2'b10;
  localparam logic [1:0] MEM_SZ_WORD = 2'b11;

  // LSU control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10
  } lsu_state_e;

  // Request fields kept for the response phase
  typedef struct packed {
    logic             is_load;
    logic [1:0]       size;
    logic [1:0]       offset;
    logic             uns;
    logic [REG_W-1:0] rd;
  } lsu_req_t;

  // Byte enables for an access of the given size at the given byte offset
  function automatic logic [BE_W-1:0] lsu_byte_en(input logic [1:0] size,
                                                  input logic [1:0] offset);
    logic [BE_W-1:0] be;
    case (size)
      MEM_SZ_BYTE: be = 4'b0001 << offset;
      MEM_SZ_HALF: be = 4'b0011 << {offset[1], 1'b0};
      default:     be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate LSB-justified store data across every lane it may land in
  function automatic logic [DATA_W-1:0] lsu_store_data(input logic [1:0]        size,
                                                       input logic [DATA_W-1:0] wdata);
    logic [DATA_W-1:0] d;
    case (size)
      MEM_SZ_BYTE: d = {4{wdata[7:0]}};
      MEM_SZ_HALF: d = {2{wdata[15:0]}};
      default:     d = wdata;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: picks the addressed lane and sign/zero extends it.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [1:0]        size_i,
  input  logic [1:0]        offset_i,
  input  logic              unsigned_i,
  output logic [DATA_W-1:0] data_o
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Lane select and extension; word (and none) pass through untouched
  always_comb begin
    lane_b = 8'(rdata_i >> {offset_i, 3'b000});
    lane_h = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (size_i)
      MEM_SZ_BYTE: data_o = {{24{~unsigned_i & lane_b[7]}}, lane_b};
      MEM_SZ_HALF: data_o = {{16{~unsigned_i & lane_h[15]}}, lane_h};
      default:     data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one outstanding data-bus transaction at a time.
// Optional LSU_MISALIGN_TRAP_EN: misaligned half/word accesses are trapped
// (misaligned_o pulse, no bus access) instead of being forced aligned.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       mem_read_i,
  input  logic [1:0]       mem_write_i,
  input  logic             unsigned_i,
  input  logic [XLEN-1:0]  addr_i,
  input  logic [XLEN-1:0]  wdata_i,
  input  logic [REG_W-1:0] rd_i,
  output logic             bus_req_o,
  output logic             bus_we_o,
  output logic [XLEN-1:0]  bus_addr_o,
  output logic [BE_W-1:0]  bus_be_o,
  output logic [XLEN-1:0]  bus_wdata_o,
  input  logic             bus_gnt_i,
  input  logic             bus_rvalid_i,
  input  logic [XLEN-1:0]  bus_rdata_i,
  output logic             resp_valid_o,
  output logic [XLEN-1:0]  rdata_o,
  output logic [REG_W-1:0] rd_o,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic             misaligned_o,
`endif
  output logic             stall_o
);

  lsu_state_e        state_q;
  lsu_req_t          req_q;
  logic              is_load;
  logic              op_valid;
  logic [1:0]        size;
  logic              misal;
  logic              req_fire;
  logic [DATA_W-1:0] load_data;

  // Decode the incoming request; a read wins over a simultaneous write
  always_comb begin
    is_load  = (mem_read_i != MEM_SZ_NONE);
    op_valid = is_load || (mem_write_i != MEM_SZ_NONE);
    size     = is_load ? mem_read_i : mem_write_i;
    req_fire = (state_q == ST_IDLE) && req_valid_i && op_valid;
  end

`ifdef LSU_MISALIGN_TRAP_EN
  // Half needs addr[0]=0, word needs addr[1:0]=00
  assign misal = ((size == MEM_SZ_HALF) && addr_i[0]) ||
                 ((size == MEM_SZ_WORD) && (addr_i[1:0] != 2'b00));
`else
  // Misaligned low bits are simply ignored by lane logic
  assign misal = 1'b0;
`endif

  assign req_ready_o = (state_q == ST_IDLE);
  assign stall_o     = (state_q != ST_IDLE) || (req_valid_i && op_valid);

  lsu_load_align u_load_align (
    .rdata_i    (bus_rdata_i),
    .size_i     (req_q.size),
    .offset_i   (req_q.offset),
    .unsigned_i (req_q.uns),
    .data_o     (load_data)
  );

  // Control FSM with registered bus and response outputs
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      req_q        <= '0;
      bus_req_o    <= 1'b0;
      bus_we_o     <= 1'b0;
      bus_addr_o   <= '0;
      bus_be_o     <= '0;
      bus_wdata_o  <= '0;
      resp_valid_o <= 1'b0;
      rdata_o      <= '0;
      rd_o         <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      misaligned_o <= 1'b0;
`endif
    end else begin
      resp_valid_o <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      misaligned_o <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (req_fire) begin
            req_q.is_load <= is_load;
            req_q.size    <= size;
            req_q.offset  <= addr_i[1:0];
            req_q.uns     <= unsigned_i;
            req_q.rd      <= rd_i;
            if (misal) begin
`ifdef LSU_MISALIGN_TRAP_EN
              misaligned_o <= 1'b1;
`endif
            end else begin
              state_q     <= ST_REQ;
              bus_req_o   <= 1'b1;
              bus_we_o    <= ~is_load;
              bus_addr_o  <= {addr_i[XLEN-1:2], 2'b00};
              bus_be_o    <= lsu_byte_en(size, addr_i[1:0]);
              bus_wdata_o <= lsu_store_data(size, wdata_i);
            end
          end
        end
        ST_REQ: begin
          if (bus_gnt_i) begin
            bus_req_o <= 1'b0;
            state_q   <= req_q.is_load ? ST_WAIT : ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (bus_rvalid_i) begin
            rdata_o      <= load_data;
            rd_o         <= req_q.rd;
            resp_valid_o <= 1'b1;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: the driver pushes expected bus requests and load
// responses; independent monitors compare whenever the DUT presents them.
module tb_lsu;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } bus_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  mem_read_i;
  logic [1:0]  mem_write_i;
  logic        unsigned_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [4:0]  rd_i;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_gnt_i;
  logic        bus_rvalid_i;
  logic [31:0] bus_rdata_i;
  logic        resp_valid_o;
  logic [31:0] rdata_o;
  logic [4:0]  rd_o;
  logic        stall_o;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misaligned_o;
  logic        mis_expect = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bus_t  exp_bus[$];
  resp_t exp_resp[$];

  always #5 clk = ~clk;

  lsu dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .mem_read_i   (mem_read_i),
    .mem_write_i  (mem_write_i),
    .unsigned_i   (unsigned_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .rd_i         (rd_i),
    .bus_req_o    (bus_req_o),
    .bus_we_o     (bus_we_o),
    .bus_addr_o   (bus_addr_o),
    .bus_be_o     (bus_be_o),
    .bus_wdata_o  (bus_wdata_o),
    .bus_gnt_i    (bus_gnt_i),
    .bus_rvalid_i (bus_rvalid_i),
    .bus_rdata_i  (bus_rdata_i),
    .resp_valid_o (resp_valid_o),
    .rdata_o      (rdata_o),
    .rd_o         (rd_o),
`ifdef LSU_MISALIGN_TRAP_EN
    .misaligned_o (misaligned_o),
`endif
    .stall_o      (stall_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference load result from the size/extension rules
  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic [31:0] addr,
                                             input logic uns, input logic [31:0] rdata);
    logic [31:0] v;
    case (sz)
      2'd1: begin
        v = (rdata >> (8 * addr[1:0])) & 32'hFF;
        if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
      end
      2'd2: begin
        v = (rdata >> (16 * addr[1])) & 32'hFFFF;
        if (!uns && v >= 32'd32768) v = v + 32'hFFFF_0000;
      end
      default: v = rdata;
    endcase
    return v;
  endfunction

  // Bus request monitor: outputs must match (and hold) until granted
  always @(negedge clk) begin
    if (bus_req_o === 1'b1) begin
      if (exp_bus.size() == 0) begin
        chk("bus_req_unexpected", 32'(bus_req_o), 32'd0);
      end else begin
        chk("bus_addr", bus_addr_o, exp_bus[0].addr);
        chk("bus_be", 32'(bus_be_o), 32'(exp_bus[0].be));
        chk("bus_we", 32'(bus_we_o), 32'(exp_bus[0].we));
        if (exp_bus[0].we) chk("bus_wdata", bus_wdata_o, exp_bus[0].wdata);
        if (bus_gnt_i) void'(exp_bus.pop_front());
      end
    end
  end

  // Load response monitor
  always @(negedge clk) begin
    if (resp_valid_o === 1'b1) begin
      if (exp_resp.size() == 0) begin
        chk("resp_unexpected", 32'(resp_valid_o), 32'd0);
      end else begin
        chk("rdata", rdata_o, exp_resp[0].data);
        chk("rd", 32'(rd_o), 32'(exp_resp[0].rd));
        void'(exp_resp.pop_front());
      end
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always @(negedge clk) begin
    if (misaligned_o === 1'b1 && !mis_expect) chk("misaligned_unexpected", 32'(misaligned_o), 32'd0);
  end
`endif

  task automatic idle_inputs();
    req_valid_i = 1'b0;
    mem_read_i  = 2'd0;
    mem_write_i = 2'd0;
    unsigned_i  = 1'b0;
    addr_i      = $urandom;
    wdata_i     = $urandom;
    rd_i        = 5'($urandom);
  endtask

  // One request through acceptance, bus phase and (for loads) response
  task automatic do_op(input logic [1:0] rsz, input logic [1:0] wsz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                       input int gdly, input int rdly, input logic [31:0] rdat);
    logic [1:0] sz;
    logic       ld;
    logic       mis;
    bus_t       eb;
    resp_t      er;
    ld  = (rsz != 2'd0);
    sz  = ld ? rsz : wsz;
    mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    mis = (sz == 2'd2 && addr[0]) || (sz == 2'd3 && addr[1:0] != 2'd0);
`endif
    req_valid_i = 1'b1;
    mem_read_i  = rsz;
    mem_write_i = wsz;
    unsigned_i  = uns;
    addr_i      = addr;
    wdata_i     = wdata;
    rd_i        = rd;
    @(negedge clk);
    chk("ready_at_req", 32'(req_ready_o), 32'd1);
    chk("stall_at_req", 32'(stall_o), 32'd1);
    if (!mis) begin
      eb.addr  = addr & 32'hFFFF_FFFC;
      eb.we    = !ld;
      eb.be    = (sz == 2'd1) ? 4'(1 << addr[1:0]) :
                 (sz == 2'd2) ? 4'(3 << (addr[1:0] & 2'd2)) : 4'hF;
      eb.wdata = (sz == 2'd1) ? (wdata & 32'hFF) * 32'h0101_0101 :
                 (sz == 2'd2) ? (wdata & 32'hFFFF) * 32'h0001_0001 : wdata;
      exp_bus.push_back(eb);
    end
    @(posedge clk); #1;
    idle_inputs();
    if (mis) begin
`ifdef LSU_MISALIGN_TRAP_EN
      mis_expect = 1'b1;
      @(negedge clk);
      chk("misaligned_pulse", 32'(misaligned_o), 32'd1);
      chk("misaligned_no_bus", 32'(bus_req_o), 32'd0);
      chk("misaligned_idle", 32'(req_ready_o), 32'd1);
      @(posedge clk); #1;
      mis_expect = 1'b0;
      @(negedge clk);
      chk("misaligned_one_cycle", 32'(misaligned_o), 32'd0);
      chk("misaligned_still_no_bus", 32'(bus_req_o), 32'd0);
      @(posedge clk); #1;
`endif
      return;
    end
    for (int i = 0; i < gdly; i++) begin
      bus_rvalid_i = 1'($urandom_range(1, 0));
      bus_rdata_i  = $urandom;
      @(negedge clk);
      chk("stall_in_req", 32'(stall_o), 32'd1);
      chk("not_ready_in_req", 32'(req_ready_o), 32'd0);
      @(posedge clk); #1;
    end
    bus_rvalid_i = 1'b0;
    bus_gnt_i    = 1'b1;
    @(negedge clk);
    chk("stall_at_gnt", 32'(stall_o), 32'd1);
    chk("req_at_gnt", 32'(bus_req_o), 32'd1);
    @(posedge clk); #1;
    bus_gnt_i = 1'b0;
    if (!ld) begin
      @(negedge clk);
      chk("store_idle", 32'(req_ready_o), 32'd1);
      chk("store_no_stall", 32'(stall_o), 32'd0);
      chk("store_req_drop", 32'(bus_req_o), 32'd0);
      @(posedge clk); #1;
      return;
    end
    er.data = model_load(sz, addr, uns, rdat);
    er.rd   = rd;
    for (int i = 0; i < rdly; i++) begin
      bus_gnt_i   = 1'($urandom_range(1, 0));
      bus_rdata_i = $urandom;
      @(negedge clk);
      chk("stall_in_wait", 32'(stall_o), 32'd1);
      chk("no_resp_in_wait", 32'(resp_valid_o), 32'd0);
      @(posedge clk); #1;
    end
    bus_gnt_i    = 1'b0;
    exp_resp.push_back(er);
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = rdat;
    @(negedge clk);
    chk("stall_at_rvalid", 32'(stall_o), 32'd1);
    @(posedge clk); #1;
    bus_rvalid_i = 1'b0;
    bus_rdata_i  = $urandom;
    @(negedge clk);
    chk("resp_after_rvalid", 32'(resp_valid_o), 32'd1);
    chk("load_idle", 32'(req_ready_o), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(req_ready_o), 32'd1);
    chk({tag, "_stall"}, 32'(stall_o), 32'd0);
    chk({tag, "_bus_req"}, 32'(bus_req_o), 32'd0);
    chk({tag, "_bus_we"}, 32'(bus_we_o), 32'd0);
    chk({tag, "_bus_addr"}, bus_addr_o, 32'd0);
    chk({tag, "_bus_be"}, 32'(bus_be_o), 32'd0);
    chk({tag, "_bus_wdata"}, bus_wdata_o, 32'd0);
    chk({tag, "_resp_valid"}, 32'(resp_valid_o), 32'd0);
    chk({tag, "_rdata"}, rdata_o, 32'd0);
    chk({tag, "_rd"}, 32'(rd_o), 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk({tag, "_misaligned"}, 32'(misaligned_o), 32'd0);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] rs;
    logic [1:0] ws;
    rst_ni       = 1'b0;
    bus_gnt_i    = 1'b0;
    bus_rvalid_i = 1'b0;
    bus_rdata_i  = 32'd0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_ni = 1'b1;

    // SW 0x1004, immediate grant
    do_op(2'd0, 2'd3, 1'b0, 32'h0000_1004, 32'hDEAD_BEEF, 5'd0, 0, 0, 32'd0);
    // LB / LBU from top lane
    do_op(2'd1, 2'd0, 1'b0, 32'h0000_2003, 32'd0, 5'd5, 1, 1, 32'h8012_3456);
    do_op(2'd1, 2'd0, 1'b1, 32'h0000_2003, 32'd0, 5'd6, 0, 0, 32'h80AB_CDEF);
    // SH 0x0002
    do_op(2'd0, 2'd2, 1'b0, 32'h0000_0002, 32'h0000_1234, 5'd0, 0, 0, 32'd0);
    // LW with delayed grant and data
    do_op(2'd3, 2'd0, 1'b0, 32'h0000_0040, 32'd0, 5'd17, 3, 2, 32'hCAFE_F00D);
    // Read and write together: the read is performed
    do_op(2'd2, 2'd1, 1'b0, 32'h0000_3002, 32'h5555_AAAA, 5'd9, 0, 1, 32'h8765_4321);

    // Reset while waiting for read data; the late rvalid must be dropped
    req_valid_i = 1'b1;
    mem_read_i  = 2'd3;
    addr_i      = 32'h0000_0100;
    rd_i        = 5'd21;
    exp_bus.push_back('{addr: 32'h0000_0100, be: 4'hF, we: 1'b0, wdata: 32'd0});
    @(posedge clk); #1;
    idle_inputs();
    bus_gnt_i = 1'b1;
    @(posedge clk); #1;
    bus_gnt_i = 1'b0;
    @(negedge clk);
    chk("in_wait_before_reset", 32'(req_ready_o), 32'd0);
    @(posedge clk); #1;
    rst_ni = 1'b0;
    @(posedge clk); #1;
    rst_ni = 1'b1;
    @(negedge clk);
    check_reset_outputs("midreset");
    @(posedge clk); #1;
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 32'h1357_9BDF;
    @(posedge clk); #1;
    bus_rvalid_i = 1'b0;
    @(negedge clk);
    chk("late_rvalid_dropped", 32'(resp_valid_o), 32'd0);
    chk("late_rvalid_idle", 32'(req_ready_o), 32'd1);
    @(posedge clk); #1;

    // Valid without an operation is not accepted
    req_valid_i = 1'b1;
    @(negedge clk);
    chk("noop_no_stall", 32'(stall_o), 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("noop_no_bus", 32'(bus_req_o), 32'd0);
    chk("noop_idle", 32'(req_ready_o), 32'd1);
    @(posedge clk); #1;

    // LW 0x0006: trapped or forced aligned, depending on build
    do_op(2'd3, 2'd0, 1'b0, 32'h0000_0006, 32'd0, 5'd3, 0, 0, 32'h0BAD_F00D);
    do_op(2'd0, 2'd2, 1'b0, 32'h0000_0007, 32'h0000_BEEF, 5'd0, 1, 0, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      rs = 2'($urandom_range(3, 0));
      ws = 2'($urandom_range(3, 0));
      if (rs == 2'd0 && ws == 2'd0) rs = 2'd3;
      do_op(rs, ws, 1'($urandom_range(1, 0)), $urandom, $urandom, 5'($urandom),
            int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), $urandom);
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("bus_queue_drained", 32'(exp_bus.size()), 32'd0);
    chk("resp_queue_drained", 32'(exp_resp.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width; only 32 is supported.
REQ-002 SHALL have clk_i, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have rst_ni, input, 1: synchronous, active-low reset.
REQ-004 SHALL have req_valid_i, input, 1: memory request present from the execute stage.
REQ-005 SHALL have req_ready_o, output, 1: request accepted this cycle.
REQ-006 SHALL have mem_read_i, input, 2: load size; 00 none, 01 byte, 10 half, 11 word.
REQ-007 SHALL have mem_write_i, input, 2: store size, same encoding as mem_read_i.
REQ-008 SHALL have unsigned_i, input, 1: funct3[2]; zero-extend loads when 1.
REQ-009 SHALL have addr_i, input, 32: byte address.
REQ-010 SHALL have wdata_i, input, 32: store data, LSB-justified.
REQ-011 SHALL have rd_i, input, 5: load destination register.
REQ-012 SHALL have bus_req_o, output, 1: data-bus request.
REQ-013 SHALL have bus_we_o, output, 1: bus write.
REQ-014 SHALL have bus_addr_o, output, 32: word-aligned address, bits [1:0] = 00.
REQ-015 SHALL have bus_be_o, output, 4: byte enables.
REQ-016 SHALL have bus_wdata_o, output, 32: lane-replicated store data.
REQ-017 SHALL have bus_gnt_i, input, 1: bus accepted request.
REQ-018 SHALL have bus_rvalid_i, input, 1: read data valid.
REQ-019 SHALL have bus_rdata_i, input, 32: read data.
REQ-020 SHALL have resp_valid_o, output, 1: load result valid, one-cycle pulse.
REQ-021 SHALL have rdata_o, output, 32: aligned, extended load result.
REQ-022 SHALL have rd_o, output, 5: destination of rdata_o.
REQ-023 SHALL have stall_o, output, 1: pipeline must hold.

Function
REQ-024 SHALL implement FSM IDLE, REQ, WAIT; req_ready_o = 1 only in IDLE.
REQ-025 SHALL accept a request in IDLE when req_valid_i is high and mem_read_i or mem_write_i is non-zero; it latches the address, size, data, unsigned_i and rd_i, then enters REQ.
REQ-026 SHALL perform the read and ignore the write when mem_read_i and mem_write_i are both non-zero.
REQ-027 SHALL hold bus_req_o and all bus_* outputs stable in REQ until bus_gnt_i; on grant, a store returns to IDLE and a load enters WAIT.
REQ-028 SHALL, in WAIT, on bus_rvalid_i register rdata_o, pulse resp_valid_o for exactly 1 cycle, and return to IDLE.
REQ-029 SHALL, as minimum load latency, assert bus_req_o the cycle after acceptance and resp_valid_o the cycle after bus_rvalid_i.
REQ-030 SHALL generate byte enables as byte: 0001<<addr[1:0]; half: 0011<<{addr[1],0}; word: 1111.
REQ-031 SHALL replicate store data as byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word unchanged.
REQ-032 SHALL select load data from the addressed lane and sign-extend it, or zero-extend it if unsigned_i is set; words SHALL pass through unchanged.
REQ-033 SHALL drive stall_o = (state != IDLE) || (req_valid_i && operation non-zero).
REQ-034 SHALL ignore bus_rvalid_i in IDLE and REQ.
REQ-035 SHALL ignore bus_gnt_i when bus_req_o is low.

Reset
REQ-036 SHALL, with rst_ni low at a clock edge, enter IDLE and drive bus_req_o, bus_we_o, resp_valid_o and misaligned_o to 0, and bus_addr_o, bus_be_o, bus_wdata_o, rdata_o and rd_o to 0, including when reset occurs mid-transaction; a late bus_rvalid_i after reset SHALL be discarded.

Configuration
REQ-037 SHALL, with LSU_MISALIGN_TRAP_EN defined, add output misaligned_o (1 bit); a half access with addr[0]=1, or a word access with addr[1:0]!=00, SHALL be accepted, start no bus transaction, stay in IDLE and pulse misaligned_o for 1 cycle after acceptance.
REQ-038 SHALL, without LSU_MISALIGN_TRAP_EN, omit misaligned_o and perform misaligned accesses with the offending low address bits forced to 0.

Structure
REQ-039 SHALL place the size encodings (MEM_SZ_NONE/BYTE/HALF/WORD) and the FSM state typedef in the shared core definitions package, alongside the ALU/opcode constants.
REQ-040 SHALL place lane extraction and extension in one combinational sub-module, lsu_load_align.

Verification
REQ-041 SHALL cover: SW addr 0x1004, data 0xDEADBEEF, gnt on 1st cycle -> bus_be_o=1111, bus_addr_o=0x1004, bus_we_o=1, back in IDLE 2 cycles after acceptance.
REQ-042 SHALL cover: LB addr 0x2003, rdata 0x80xxxxxx -> rdata_o=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-043 SHALL cover: SH addr 0x0002, data 0x1234 -> bus_be_o=1100, bus_wdata_o=0x12341234.
REQ-044 SHALL cover: LW with gnt delayed 3 cycles and rvalid delayed 2 cycles -> bus outputs stable, stall_o high throughout, single resp_valid_o pulse, rd_o matches rd_i.
REQ-045 SHALL cover: reset asserted in WAIT, then rvalid arrives -> IDLE, no resp_valid_o.
REQ-046 SHALL cover: LW addr 0x0006 -> with LSU_MISALIGN_TRAP_EN, misaligned_o pulses and bus_req_o stays 0; without it, bus_addr_o=0x0004 and bus_be_o=1111.
